bus_ctrl: RTL and testbench

- Parametrised i8080 bus controller replacing the ad-hoc top-level decode (single hard-wired ROM/RAM split plus a free-running status latch).
- Latches the status word on SYNC and classifies the machine cycle.
- Decodes the address against NUM_REGIONS configurable memory windows, inserts per-region wait states via READY, and gates per-region output/write enables and I/O strobes.
- Sits between the i8080 core and the memory/peripheral blocks in the system top.

---
 rtl/bus_pkg.sv | 40 ++++
 rtl/bus_region_dec.sv | 39 +++
 rtl/bus_ctrl.sv | 105 ++++++++++
 tb/tb_bus_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared encodings for the i8080 bus controller: status bit positions,
// machine-cycle classes and controller states.
package bus_pkg;

  localparam int STS_INTA  = 0;
  localparam int STS_WO_N  = 1;
  localparam int STS_STACK = 2;
  localparam int STS_HLTA  = 3;
  localparam int STS_OUT   = 4;
  localparam int STS_M1    = 5;
  localparam int STS_INP   = 6;
  localparam int STS_MEMR  = 7;

  localparam logic [2:0] CYC_NONE   = 3'd0;
  localparam logic [2:0] CYC_MEM_RD = 3'd1;
  localparam logic [2:0] CYC_MEM_WR = 3'd2;
  localparam logic [2:0] CYC_IO_RD  = 3'd3;
  localparam logic [2:0] CYC_IO_WR  = 3'd4;
  localparam logic [2:0] CYC_INTACK = 3'd5;
  localparam logic [2:0] CYC_HALT   = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_HALT   = 2'd3
  } bus_state_e;

  // Priority order matters: HLTA status also carries MEMR, INTA carries WO_n.
  function automatic logic [2:0] cyc_class(input logic [7:0] s);
    if      (s[STS_INTA])  return CYC_INTACK;
    else if (s[STS_HLTA])  return CYC_HALT;
    else if (s[STS_INP])   return CYC_IO_RD;
    else if (s[STS_OUT])   return CYC_IO_WR;
    else if (s[STS_MEMR])  return CYC_MEM_RD;
    else if (!s[STS_WO_N]) return CYC_MEM_WR;
    else                   return CYC_NONE;
  endfunction

endpackage

// File: rtl/bus_region_dec.sv
// Combinational address-window matcher; the lowest-index hit wins and
// supplies its wait-state count.
module bus_region_dec
  import bus_pkg::*;
#(
  parameter int NUM_REGIONS = 2,
  parameter int WAIT_WIDTH  = 2
) (
  input  logic [15:0]                                 addr,
  input  logic [NUM_REGIONS-1:0][15:0]                base,
  input  logic [NUM_REGIONS-1:0][15:0]                mask,
  input  logic [NUM_REGIONS-1:0][WAIT_WIDTH-1:0]      waits,
  output logic [NUM_REGIONS-1:0]                      hit_oh,
  output logic                                        hit,
  output logic [WAIT_WIDTH-1:0]                       hit_wait
);

  logic [NUM_REGIONS-1:0] match;

  for (genvar r = 0; r < NUM_REGIONS; r++) begin : g_match
    assign match[r] = (addr & mask[r]) == (base[r] & mask[r]);
  end

  // Walk from the top down so the lowest matching index overwrites last.
  always_comb begin
    hit_oh   = '0;
    hit      = 1'b0;
    hit_wait = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit_oh    = '0;
        hit_oh[i] = 1'b1;
        hit       = 1'b1;
        hit_wait  = waits[i];
      end
    end
  end

endmodule

// File: rtl/bus_ctrl.sv
// i8080 bus controller: latches status on SYNC, decodes memory windows,
// inserts wait states via READY and gates memory/I-O strobes.
module bus_ctrl
  import bus_pkg::*;
#(
  parameter int NUM_REGIONS = 2,
  parameter logic [NUM_REGIONS*16-1:0] REGION_BASE = {16'h2000, 16'h0000},
  parameter logic [NUM_REGIONS*16-1:0] REGION_MASK = {16'hE000, 16'hE000},
  parameter int WAIT_WIDTH = 2,
  parameter logic [NUM_REGIONS*WAIT_WIDTH-1:0] WAIT_STATES = {2'd0, 2'd0}
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sync,
  input  logic                   dbin,
  input  logic                   write_n,
  input  logic [15:0]            addr,
  input  logic [7:0]             data_in,
  output logic                   ready,
  output logic [7:0]             status,
  output logic [2:0]             cyc_type,
  output logic [NUM_REGIONS-1:0] region_sel,
  output logic                   region_oen,
  output logic                   region_wen,
  output logic [7:0]             io_port,
  output logic                   io_rd,
  output logic                   io_wr,
  output logic                   halted,
  output logic                   bus_err
);

  bus_state_e              state;
  logic [WAIT_WIDTH-1:0]   cnt;
  logic [NUM_REGIONS-1:0]  hit_oh;
  logic                    hit;
  logic [WAIT_WIDTH-1:0]   hit_wait;
  logic [2:0]              cls;
  logic                    is_mem;

  bus_region_dec #(
    .NUM_REGIONS (NUM_REGIONS),
    .WAIT_WIDTH  (WAIT_WIDTH)
  ) u_dec (
    .addr     (addr),
    .base     (REGION_BASE),
    .mask     (REGION_MASK),
    .waits    (WAIT_STATES),
    .hit_oh   (hit_oh),
    .hit      (hit),
    .hit_wait (hit_wait)
  );

  assign cls    = cyc_class(data_in);
  assign is_mem = (cls == CYC_MEM_RD) || (cls == CYC_MEM_WR);

  // SYNC takes precedence over everything, so a fresh T1 aborts a pending wait.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      status     <= '0;
      cyc_type   <= CYC_NONE;
      region_sel <= '0;
      io_port    <= '0;
      bus_err    <= 1'b0;
      ready      <= 1'b1;
      halted     <= 1'b0;
    end else if (sync) begin
      status     <= data_in;
      cyc_type   <= cls;
      io_port    <= addr[7:0];
      region_sel <= is_mem ? hit_oh : '0;
      if (is_mem && !hit) bus_err <= 1'b1;
      if (cls == CYC_HALT) begin
        state  <= ST_HALT;
        ready  <= 1'b1;
        halted <= 1'b1;
      end else if (is_mem && hit && hit_wait != '0) begin
        state  <= ST_WAIT;
        cnt    <= hit_wait;
        ready  <= 1'b0;
        halted <= 1'b0;
      end else begin
        state  <= ST_ACTIVE;
        ready  <= 1'b1;
        halted <= 1'b0;
      end
    end else if (state == ST_WAIT) begin
      if (cnt == WAIT_WIDTH'(1)) begin
        state <= ST_ACTIVE;
        ready <= 1'b1;
      end else begin
        cnt <= cnt - WAIT_WIDTH'(1);
      end
    end
  end

  logic active;
  assign active     = (state == ST_ACTIVE);
  assign region_oen = active & dbin     & (cyc_type == CYC_MEM_RD);
  assign region_wen = active & ~write_n & (cyc_type == CYC_MEM_WR);
  assign io_rd      = active & dbin     & (cyc_type == CYC_IO_RD);
  assign io_wr      = active & ~write_n & (cyc_type == CYC_IO_WR);

endmodule

// File: tb/tb_bus_ctrl.sv
// Directed bench for bus_ctrl: region 0 = 0x0000/0xE000 no waits,
// region 1 = 0x2000/0xE000 with two wait states.
module tb_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, sync, dbin, write_n;
  logic [15:0] addr;
  logic [7:0]  data_in;
  logic        ready, region_oen, region_wen, io_rd, io_wr, halted, bus_err;
  logic [7:0]  status, io_port;
  logic [2:0]  cyc_type;
  logic [1:0]  region_sel;

  int nchk = 0;
  int nbad = 0;

  always #5 clk = ~clk;

  bus_ctrl #(
    .NUM_REGIONS (2),
    .REGION_BASE ({16'h2000, 16'h0000}),
    .REGION_MASK ({16'hE000, 16'hE000}),
    .WAIT_WIDTH  (2),
    .WAIT_STATES ({2'd2, 2'd0})
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sync       (sync),
    .dbin       (dbin),
    .write_n    (write_n),
    .addr       (addr),
    .data_in    (data_in),
    .ready      (ready),
    .status     (status),
    .cyc_type   (cyc_type),
    .region_sel (region_sel),
    .region_oen (region_oen),
    .region_wen (region_wen),
    .io_port    (io_port),
    .io_rd      (io_rd),
    .io_wr      (io_wr),
    .halted     (halted),
    .bus_err    (bus_err)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    nchk++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One-cycle SYNC pulse; returns #1 after the latching edge.
  task automatic do_sync(input logic [7:0] d, input logic [15:0] a);
    @(negedge clk);
    sync = 1'b1; data_in = d; addr = a;
    @(posedge clk); #1;
    sync = 1'b0;
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; sync = 1'b0; dbin = 1'b0; write_n = 1'b1;
    addr = '0; data_in = '0;
    step; step;
    chk("rst_ready", 16'(ready), 16'd1);
    chk("rst_status", 16'(status), 16'h00);
    chk("rst_cyc", 16'(cyc_type), 16'd0);
    chk("rst_sel", 16'(region_sel), 16'd0);
    chk("rst_err", 16'(bus_err), 16'd0);
    chk("rst_halt", 16'(halted), 16'd0);
    @(negedge clk); rst_n = 1'b1;

    // 1: memory read in region 0, no waits
    do_sync(8'hA2, 16'h0100);
    dbin = 1'b1; #1;
    chk("t1_sel", 16'(region_sel), 16'b01);
    chk("t1_cyc", 16'(cyc_type), 16'd1);
    chk("t1_ready", 16'(ready), 16'd1);
    chk("t1_status", 16'(status), 16'hA2);
    chk("t1_oen", 16'(region_oen), 16'd1);
    dbin = 1'b0; #1;
    chk("t1_oen_off", 16'(region_oen), 16'd0);

    // 2: memory write in region 1, two wait states
    write_n = 1'b0;
    do_sync(8'h00, 16'h2400);
    chk("t2_cyc", 16'(cyc_type), 16'd2);
    chk("t2_w1", 16'(ready), 16'd0);
    chk("t2_wen_wait", 16'(region_wen), 16'd0);
    step;
    chk("t2_w2", 16'(ready), 16'd0);
    step;
    chk("t2_rdy", 16'(ready), 16'd1);
    chk("t2_sel", 16'(region_sel), 16'b10);
    chk("t2_wen", 16'(region_wen), 16'd1);
    write_n = 1'b1; #1;
    chk("t2_wen_off", 16'(region_wen), 16'd0);

    // 3: unmapped read sets sticky bus_err without waits
    do_sync(8'h82, 16'h4000);
    chk("t3_sel", 16'(region_sel), 16'd0);
    chk("t3_err", 16'(bus_err), 16'd1);
    chk("t3_ready", 16'(ready), 16'd1);
    step;
    chk("t3_ready2", 16'(ready), 16'd1);
    do_sync(8'hA2, 16'h0000);
    chk("t3_err_sticky", 16'(bus_err), 16'd1);
    chk("t3_sel2", 16'(region_sel), 16'b01);

    // 4: IN then OUT
    dbin = 1'b1;
    do_sync(8'h42, 16'h0303);
    chk("t4_port", 16'(io_port), 16'h03);
    chk("t4_iord", 16'(io_rd), 16'd1);
    chk("t4_sel", 16'(region_sel), 16'd0);
    chk("t4_oen", 16'(region_oen), 16'd0);
    dbin = 1'b0; write_n = 1'b0;
    do_sync(8'h10, 16'h0355);
    chk("t4_cyc", 16'(cyc_type), 16'd4);
    chk("t4_iowr", 16'(io_wr), 16'd1);
    chk("t4_port2", 16'(io_port), 16'h55);
    chk("t4_wen", 16'(region_wen), 16'd0);
    write_n = 1'b1;

    // 5: HALT then INTA
    do_sync(8'h8A, 16'h0010);
    dbin = 1'b1; #1;
    chk("t5_halted", 16'(halted), 16'd1);
    chk("t5_ready", 16'(ready), 16'd1);
    chk("t5_cyc", 16'(cyc_type), 16'd6);
    chk("t5_oen", 16'(region_oen), 16'd0);
    chk("t5_sel", 16'(region_sel), 16'd0);
    dbin = 1'b0;
    do_sync(8'h23, 16'h0010);
    chk("t5_unhalt", 16'(halted), 16'd0);
    chk("t5_cyc2", 16'(cyc_type), 16'd5);

    // 6: reset during the second wait cycle
    write_n = 1'b0;
    do_sync(8'h00, 16'h2400);
    chk("t6_w1", 16'(ready), 16'd0);
    step;
    chk("t6_w2", 16'(ready), 16'd0);
    @(negedge clk); rst_n = 1'b0;
    step;
    chk("t6_ready", 16'(ready), 16'd1);
    chk("t6_status", 16'(status), 16'h00);
    chk("t6_sel", 16'(region_sel), 16'd0);
    chk("t6_err", 16'(bus_err), 16'd0);
    chk("t6_wen", 16'(region_wen), 16'd0);
    write_n = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    step;
    chk("t6_idle_ready", 16'(ready), 16'd1);

    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "timeout");
  end

endmodule
